// File: rtl/counter_pkg.sv
// Shared types for the bounded up/down counter: end-of-range modes and FSM states.
package counter_pkg;

  // Default widths used by the counter and its step calculator.
  localparam int COUNTER_BITS_DEF = 8;
  localparam int STEP_BITS_DEF    = 4;

  // End-of-range behaviour selected at runtime.
  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_t;

  // Counter control state: counting, or parked after a one-shot terminal event.
  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_HALT = 1'b1
  } cnt_state_t;

endpackage : counter_pkg

// File: rtl/counter_step_calc.sv
// Combinational step calculator: given the current count, direction, step and bounds,
// produces the value after one step and flags a terminal (end-of-range) event.
// Arithmetic is carried one bit wider than the count so neither overflow nor underflow
// can alias back into range.
module counter_step_calc
  import counter_pkg::*;
#(
  parameter int COUNTER_BITS = COUNTER_BITS_DEF,
  parameter int STEP_BITS    = STEP_BITS_DEF
) (
  input  logic [COUNTER_BITS-1:0] count,
  input  logic                    dir_down,
  input  logic [STEP_BITS-1:0]    step,
  input  logic [COUNTER_BITS-1:0] lower,
  input  logic [COUNTER_BITS-1:0] upper,
  input  cnt_mode_t               mode,
  output logic [COUNTER_BITS-1:0] next_val,
  output logic                    terminal
);

  localparam int WB = COUNTER_BITS + 1;

  logic [WB-1:0]           count_x_s;
  logic [WB-1:0]           step_x_s;
  logic [WB-1:0]           lower_x_s;
  logic [WB-1:0]           upper_x_s;
  logic [WB-1:0]           sum_s;
  logic [WB-1:0]           floor_s;
  logic [COUNTER_BITS-1:0] diff_s;

  assign count_x_s = {1'b0, count};
  assign step_x_s  = WB'(step);
  assign lower_x_s = {1'b0, lower};
  assign upper_x_s = {1'b0, upper};
  assign sum_s     = count_x_s + step_x_s;
  // Down-count is terminal when count < lower + step; comparing this way never underflows.
  assign floor_s   = lower_x_s + step_x_s;
  assign diff_s    = count - COUNTER_BITS'(step);

  // Select the stepped value, or the bound to reload on a terminal event.
  always_comb begin
    terminal = 1'b0;
    next_val = count;
    if (dir_down) begin
      if (count_x_s < floor_s) begin
        terminal = 1'b1;
        case (mode)
          CNT_WRAP:    next_val = upper;
          CNT_SAT:     next_val = lower;
          CNT_ONESHOT: next_val = lower;
          default:     next_val = lower;
        endcase
      end else begin
        next_val = diff_s;
      end
    end else begin
      if (sum_s > upper_x_s) begin
        terminal = 1'b1;
        case (mode)
          CNT_WRAP:    next_val = lower;
          CNT_SAT:     next_val = upper;
          CNT_ONESHOT: next_val = upper;
          default:     next_val = upper;
        endcase
      end else begin
        next_val = sum_s[COUNTER_BITS-1:0];
      end
    end
  end

endmodule : counter_step_calc

// File: rtl/bounded_counter.sv
// Up/down counter with runtime bounds, step, load and wrap/saturate/one-shot end modes.
// All updates qualify on clk_en; priority is sync_reset > load > step.
module bounded_counter
  import counter_pkg::*;
#(
  parameter int COUNTER_BITS = COUNTER_BITS_DEF,
  parameter int STEP_BITS    = STEP_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic                    sync_reset,
  input  logic                    load,
  input  logic [COUNTER_BITS-1:0] load_val,
  input  logic                    dir_down,
  input  cnt_mode_t               mode,
  input  logic [STEP_BITS-1:0]    step,
  input  logic [COUNTER_BITS-1:0] lower,
  input  logic [COUNTER_BITS-1:0] upper,
  output logic [COUNTER_BITS-1:0] out,
  output logic                    at_limit,
  output logic                    wrap_pulse,
  output logic                    done,
  output logic                    bound_err
);

  cnt_state_t              state_r;
  cnt_state_t              state_nxt_s;
  logic [COUNTER_BITS-1:0] out_r;
  logic [COUNTER_BITS-1:0] out_nxt_s;
  logic                    pulse_r;
  logic                    pulse_nxt_s;
  logic                    done_r;
  logic [COUNTER_BITS-1:0] calc_val_s;
  logic                    calc_term_s;
  logic [COUNTER_BITS-1:0] start_val_s;
  logic                    step_go_s;

  counter_step_calc #(
    .COUNTER_BITS (COUNTER_BITS),
    .STEP_BITS    (STEP_BITS)
  ) u_step_calc (
    .count    (out_r),
    .dir_down (dir_down),
    .step     (step),
    .lower    (lower),
    .upper    (upper),
    .mode     (mode),
    .next_val (calc_val_s),
    .terminal (calc_term_s)
  );

  assign bound_err   = (lower > upper);
  assign start_val_s = dir_down ? upper : lower;
  assign step_go_s   = (state_r == CNT_RUN) && enable && (step != {STEP_BITS{1'b0}}) && !bound_err;

  // State register for the RUN/HALT FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CNT_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: one-shot terminal parks in HALT; only sync_reset or load leave it.
  always_comb begin
    state_nxt_s = state_r;
    if (clk_en) begin
      if (sync_reset || load) begin
        state_nxt_s = CNT_RUN;
      end else if (step_go_s && calc_term_s && (mode == CNT_ONESHOT)) begin
        state_nxt_s = CNT_HALT;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next count and wrap pulse, following sync_reset > load > step priority.
  always_comb begin
    out_nxt_s   = out_r;
    pulse_nxt_s = 1'b0;
    if (clk_en) begin
      if (sync_reset) begin
        out_nxt_s = start_val_s;
      end else if (load) begin
        out_nxt_s = load_val;
      end else if (step_go_s) begin
        out_nxt_s   = calc_val_s;
        pulse_nxt_s = calc_term_s && (mode == CNT_WRAP);
      end else begin
        out_nxt_s = out_r;
      end
    end else begin
      out_nxt_s = out_r;
    end
  end

  // Output registers: count, single-cycle wrap pulse and done flag mirroring HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r   <= {COUNTER_BITS{1'b0}};
      pulse_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      out_r   <= out_nxt_s;
      pulse_r <= pulse_nxt_s;
      done_r  <= (state_nxt_s == CNT_HALT);
    end
  end

  assign out        = out_r;
  assign wrap_pulse = pulse_r;
  assign done       = done_r;
  assign at_limit   = dir_down ? (out_r == lower) : (out_r == upper);

endmodule : bounded_counter

// File: tb/tb_bounded_counter.sv
// Directed testbench for bounded_counter with hand-computed expected values.
module tb_bounded_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       enable = 1'b0;
  logic       sync_reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       dir_down = 1'b0;
  cnt_mode_t  mode = CNT_WRAP;
  logic [3:0] step = 4'd1;
  logic [7:0] lower = 8'd0;
  logic [7:0] upper = 8'd255;
  logic [7:0] out;
  logic       at_limit;
  logic       wrap_pulse;
  logic       done;
  logic       bound_err;

  int n_checks = 0;
  int n_fail   = 0;

  bounded_counter #(.COUNTER_BITS(8), .STEP_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .enable     (enable),
    .sync_reset (sync_reset),
    .load       (load),
    .load_val   (load_val),
    .dir_down   (dir_down),
    .mode       (mode),
    .step       (step),
    .lower      (lower),
    .upper      (upper),
    .out        (out),
    .at_limit   (at_limit),
    .wrap_pulse (wrap_pulse),
    .done       (done),
    .bound_err  (bound_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk_en tick; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en     = 1'b0;
    sync_reset = 1'b0;
    load       = 1'b0;
  endtask

  // One clock with clk_en low.
  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    enable   = 1'b0;
    load     = 1'b1;
    load_val = v;
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pulse", 32'(wrap_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // 1. async reset mid-count
    do_load(8'd37);
    check_eq("t1_load37", 32'(out), 32'd37);
    reset = 1'b0;
    #1;
    check_eq("t1_async_out", 32'(out), 32'd0);
    check_eq("t1_async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    check_eq("t1_c0", 32'(out), 32'd0);
    mode = CNT_WRAP; lower = 8'd0; upper = 8'd255; step = 4'd1; dir_down = 1'b0; enable = 1'b1;
    tick();
    check_eq("t1_c1", 32'(out), 32'd1);
    tick();
    check_eq("t1_c2", 32'(out), 32'd2);
    idle();
    check_eq("t1_hold_no_en", 32'(out), 32'd2);

    // 2. WRAP up 3..7 step 2
    lower = 8'd3; upper = 8'd7; step = 4'd2; mode = CNT_WRAP; enable = 1'b0;
    sync_reset = 1'b1;
    tick();
    check_eq("t2_start", 32'(out), 32'd3);
    enable = 1'b1;
    tick();
    check_eq("t2_5", 32'(out), 32'd5);
    check_eq("t2_pulse5", 32'(wrap_pulse), 32'd0);
    tick();
    check_eq("t2_7", 32'(out), 32'd7);
    check_eq("t2_pulse7", 32'(wrap_pulse), 32'd0);
    check_eq("t2_atlim7", 32'(at_limit), 32'd1);
    tick();
    check_eq("t2_wrap3", 32'(out), 32'd3);
    check_eq("t2_pulse_wrap", 32'(wrap_pulse), 32'd1);
    idle();
    check_eq("t2_pulse_drop", 32'(wrap_pulse), 32'd0);
    check_eq("t2_hold3", 32'(out), 32'd3);

    // 3. SAT down 2..9 step 3
    lower = 8'd2; upper = 8'd9; step = 4'd3; mode = CNT_SAT; dir_down = 1'b1;
    do_load(8'd9);
    check_eq("t3_load9", 32'(out), 32'd9);
    enable = 1'b1;
    tick();
    check_eq("t3_6", 32'(out), 32'd6);
    tick();
    check_eq("t3_3", 32'(out), 32'd3);
    tick();
    check_eq("t3_sat2", 32'(out), 32'd2);
    check_eq("t3_atlim", 32'(at_limit), 32'd1);
    check_eq("t3_nopulse", 32'(wrap_pulse), 32'd0);
    tick();
    check_eq("t3_stay2", 32'(out), 32'd2);
    check_eq("t3_nopulse2", 32'(wrap_pulse), 32'd0);

    // 4. ONESHOT up 0..5 step 1
    lower = 8'd0; upper = 8'd5; step = 4'd1; mode = CNT_ONESHOT; dir_down = 1'b0; enable = 1'b0;
    sync_reset = 1'b1;
    tick();
    check_eq("t4_start", 32'(out), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t4_at5", 32'(out), 32'd5);
    check_eq("t4_done_pre", 32'(done), 32'd0);
    tick();
    check_eq("t4_sat5", 32'(out), 32'd5);
    check_eq("t4_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t4_halt_out", 32'(out), 32'd5);
    check_eq("t4_halt_done", 32'(done), 32'd1);
    load = 1'b1; load_val = 8'd1;
    tick();
    check_eq("t4_load1", 32'(out), 32'd1);
    check_eq("t4_done_clr", 32'(done), 32'd0);
    tick();
    check_eq("t4_count2", 32'(out), 32'd2);

    // 5. no overflow / underflow at the 8-bit edges
    lower = 8'd20; upper = 8'd255; step = 4'd15; mode = CNT_WRAP; dir_down = 1'b0;
    do_load(8'd250);
    enable = 1'b1;
    tick();
    check_eq("t5_ovf_wrap", 32'(out), 32'd20);
    check_eq("t5_ovf_pulse", 32'(wrap_pulse), 32'd1);
    lower = 8'd0; step = 4'd5; dir_down = 1'b1; mode = CNT_SAT;
    do_load(8'd2);
    enable = 1'b1;
    tick();
    check_eq("t5_udf_sat", 32'(out), 32'd0);
    mode = CNT_WRAP;
    do_load(8'd2);
    enable = 1'b1;
    tick();
    check_eq("t5_udf_wrap", 32'(out), 32'd255);
    check_eq("t5_udf_pulse", 32'(wrap_pulse), 32'd1);

    // 6. inverted bounds
    lower = 8'd10; upper = 8'd4; step = 4'd1; dir_down = 1'b0; mode = CNT_WRAP;
    #1;
    check_eq("t6_berr", 32'(bound_err), 32'd1);
    do_load(8'd7);
    check_eq("t6_load_berr", 32'(out), 32'd7);
    enable = 1'b1;
    tick();
    check_eq("t6_held", 32'(out), 32'd7);
    sync_reset = 1'b1; load = 1'b1; load_val = 8'd50;
    tick();
    check_eq("t6_srst_wins", 32'(out), 32'd10);
    sync_reset = 1'b1; load = 1'b1; load_val = 8'd99;
    idle();
    check_eq("t6_no_clken", 32'(out), 32'd10);
    sync_reset = 1'b0; load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_bounded_counter
